// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int DMEM_DEPTH = 1024;
  localparam int DMEM_AW    = 10;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

endpackage

// File: rtl/dmem_addr_check.sv
// Byte-to-word address translation with alignment and range checks.
module dmem_addr_check #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] word_idx,
  output logic          misaligned,
  output logic          out_of_range
);

  assign word_idx     = addr[AW+1:2];
  assign misaligned   = |addr[1:0];
  assign out_of_range = (addr >= (32'(DEPTH) << 2));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port word memory, with port-1 burst lock.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic        req_lock,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1,
  output logic [31:0] perf_conflict
`endif
);

  arb_state_t state, state_nxt;
  logic       rr_ptr, rr_ptr_nxt;
  logic [1:0] grant;

  logic          sel;
  logic          accept;
  logic [31:0]   win_addr;
  logic [AW-1:0] word_idx;
  logic          misaligned, out_of_range, addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // rr_ptr always points at the port that did not win; leaving a lock hands priority back to the core.
  always_comb begin
    grant      = 2'b00;
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (req_valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
        else                    grant = req_valid;
        if (grant[PORT_DMA] && req_lock) begin
          state_nxt  = ARB_LOCKED;
          rr_ptr_nxt = 1'b0;
        end else if (grant != 2'b00) begin
          rr_ptr_nxt = grant[PORT_CORE];
        end
      end
      ARB_LOCKED: begin
        grant[PORT_DMA] = req_valid[PORT_DMA];
        rr_ptr_nxt      = 1'b0;
        if (!req_valid[PORT_DMA] || !req_lock) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign req_ready = rst ? 2'b00 : grant;
  assign accept    = |req_ready;
  assign sel       = req_ready[PORT_DMA];
  assign win_addr  = sel ? req_addr1 : req_addr0;

  dmem_addr_check #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_addr_check (
    .addr        (win_addr),
    .word_idx    (word_idx),
    .misaligned  (misaligned),
    .out_of_range(out_of_range)
  );

  assign addr_err  = misaligned | out_of_range;
  assign mem_addr  = {{(32-AW){1'b0}}, word_idx};
  assign mem_wdata = sel ? req_wdata1 : req_wdata0;
  assign mem_we    = accept & req_we[sel] & ~addr_err;

  // Read data is captured in the accept cycle so the memory is free for the next requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 2'b00;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= req_ready;
      rsp_err   <= accept & addr_err;
      rsp_rdata <= (accept && !req_we[sel] && !addr_err) ? mem_rdata : 32'd0;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (&req_valid) | (req_valid[PORT_CORE] & (state == ARB_LOCKED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant0   <= 32'd0;
      perf_grant1   <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (req_ready[PORT_CORE]) perf_grant0 <= perf_grant0 + 32'd1;
      if (req_ready[PORT_DMA])  perf_grant1 <= perf_grant1 + 32'd1;
      if (conflict)             perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_dmem_arbiter;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic        req_lock;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_grant0  (perf_grant0),
    .perf_grant1  (perf_grant1),
    .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write on the rising edge.
  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept in plain integers and arrays.
  logic [31:0] m_mem [DEPTH];
  bit          m_locked;
  int          m_favour;
  int          last_g;
  int          pg0, pg1, pconf;
  logic [1:0]  obs_ready;
  logic        obs_mem_we;
  logic [31:0] obs_mem_addr;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_favour = 0;
    pg0 = 0; pg1 = 0; pconf = 0;
  endtask

  // One clock cycle: predict grant and memory drive mid-cycle, then the response after the edge.
  task automatic step();
    int          g;
    logic [31:0] a, idx, nrd;
    logic        w, e, ne;
    logic [1:0]  er;
    bit          conf;
    #3;
    if (m_locked)                g = req_valid[1] ? 1 : -1;
    else if (req_valid == 2'b11) g = m_favour;
    else if (req_valid[0])       g = 0;
    else if (req_valid[1])       g = 1;
    else                         g = -1;
    er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    obs_ready = req_ready; obs_mem_we = mem_we; obs_mem_addr = mem_addr;
    check_output("req_ready", {30'd0, req_ready}, {30'd0, er});
    a = 32'd0; w = 1'b0; e = 1'b0; idx = 32'd0;
    if (g >= 0) begin
      a   = (g == 1) ? req_addr1 : req_addr0;
      w   = req_we[g];
      e   = (a % 4 != 0) || (a >= 4 * DEPTH);
      idx = (a / 4) % DEPTH;
      check_output("mem_addr", mem_addr, idx);
      check_output("mem_we", {31'd0, mem_we}, {31'd0, w && !e});
      if (w && !e) check_output("mem_wdata", mem_wdata, (g == 1) ? req_wdata1 : req_wdata0);
    end else begin
      check_output("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
    nrd  = (g >= 0 && !w && !e) ? m_mem[idx] : 32'd0;
    ne   = (g >= 0) && e;
    conf = (req_valid == 2'b11) || (req_valid[0] && m_locked);
    if (g >= 0 && w && !e) m_mem[idx] = (g == 1) ? req_wdata1 : req_wdata0;
    if (m_locked) begin
      if (!req_valid[1] || !req_lock) begin m_locked = 1'b0; m_favour = 0; end
    end else if (g >= 0) begin
      m_favour = 1 - g;
      if (g == 1 && req_lock) m_locked = 1'b1;
    end
    if (g == 0) pg0++;
    if (g == 1) pg1++;
    if (conf) pconf++;
    last_g = g;
    @(posedge clk); #1;
    check_output("rsp_valid", {30'd0, rsp_valid}, {30'd0, er});
    check_output("rsp_err", {31'd0, rsp_err}, {31'd0, ne});
    check_output("rsp_rdata", rsp_rdata, nrd);
`ifdef DMEM_ARB_PERF_EN
    check_output("perf_grant0", perf_grant0, 32'(pg0));
    check_output("perf_grant1", perf_grant1, 32'(pg1));
    check_output("perf_conflict", perf_conflict, 32'(pconf));
`endif
  endtask

  task automatic apply_stimulus(input logic [1:0] v, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic lock);
    req_valid = v; req_we = we;
    req_addr0 = a0; req_wdata0 = d0;
    req_addr1 = a1; req_wdata1 = d1;
    req_lock  = lock;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    if (k == 1) return $urandom() | 32'h0000_1000;
    if (k == 2) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 32'd0; m_mem[i] = 32'd0; end
    model_reset();
    last_g = -1;

    // Reset state, with a write request pending that must not reach memory.
    rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b11; req_lock = 1'b0;
    req_addr0 = 32'h40; req_wdata0 = 32'h1111_1111;
    req_addr1 = 32'h44; req_wdata1 = 32'h2222_2222;
    @(posedge clk); #1;
    check_output("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_output("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_output("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    check_output("rst_perf_grant0", perf_grant0, 32'd0);
    check_output("rst_perf_conflict", perf_conflict, 32'd0);
`endif
    req_valid = 2'b00; req_we = 2'b00;
    rst = 1'b0;

    // Reset in the middle of a response drops it.
    apply_stimulus(2'b01, 2'b00, 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'h40; req_wdata0 = 32'hBAD0_BAD0;
    #3 rst = 1'b1;
    #1;
    check_output("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_output("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check_output("midrst_mem_we_edge", {31'd0, mem_we}, 32'd0);
    check_output("midrst_mem_untouched", mem[16], 32'd0);
    req_valid = 2'b00; req_we = 2'b00;
    rst = 1'b0;
    model_reset();
    apply_stimulus(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    apply_stimulus(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Contention: four cycles with both ports valid alternate 0,1,0,1.
    apply_stimulus(2'b11, 2'b00, 32'h00, 32'd0, 32'h04, 32'd0, 1'b0);
    check_output("cont_g1", {30'd0, obs_ready}, 32'd1);
    apply_stimulus(2'b11, 2'b00, 32'h08, 32'd0, 32'h04, 32'd0, 1'b0);
    check_output("cont_g2", {30'd0, obs_ready}, 32'd2);
    apply_stimulus(2'b11, 2'b00, 32'h08, 32'd0, 32'h0C, 32'd0, 1'b0);
    check_output("cont_g3", {30'd0, obs_ready}, 32'd1);
    apply_stimulus(2'b11, 2'b00, 32'h10, 32'd0, 32'h0C, 32'd0, 1'b0);
    check_output("cont_g4", {30'd0, obs_ready}, 32'd2);
`ifdef DMEM_ARB_PERF_EN
    check_output("cont_perf_grant0", perf_grant0, 32'd2);
    check_output("cont_perf_grant1", perf_grant1, 32'd2);
    check_output("cont_perf_conflict", perf_conflict, 32'd4);
`endif

    // Single port write then read-after-write.
    apply_stimulus(2'b01, 2'b01, 32'h10, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
    check_output("sp_mem_addr", obs_mem_addr, 32'd4);
    check_output("sp_mem_we", {31'd0, obs_mem_we}, 32'd1);
    apply_stimulus(2'b01, 2'b00, 32'h10, 32'd0, 32'd0, 32'd0, 1'b0);
    check_output("sp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check_output("sp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Locked burst from port 1 holds off a waiting port 0.
    apply_stimulus(2'b11, 2'b10, 32'h80, 32'd0, 32'h100, 32'hA0A0_0001, 1'b1);
    check_output("lock_b1", {30'd0, obs_ready}, 32'd2);
    apply_stimulus(2'b11, 2'b10, 32'h80, 32'd0, 32'h104, 32'hA0A0_0002, 1'b1);
    check_output("lock_b2", {30'd0, obs_ready}, 32'd2);
    apply_stimulus(2'b11, 2'b10, 32'h80, 32'd0, 32'h108, 32'hA0A0_0003, 1'b0);
    check_output("lock_b3", {30'd0, obs_ready}, 32'd2);
    apply_stimulus(2'b01, 2'b00, 32'h80, 32'd0, 32'd0, 32'd0, 1'b0);
    check_output("lock_after", {30'd0, obs_ready}, 32'd1);

    // Misaligned read and out-of-range write.
    apply_stimulus(2'b01, 2'b00, 32'h13, 32'd0, 32'd0, 32'd0, 1'b0);
    check_output("err_rd_err", {31'd0, rsp_err}, 32'd1);
    check_output("err_rd_data", rsp_rdata, 32'd0);
    apply_stimulus(2'b01, 2'b01, 32'h1000, 32'h5555_5555, 32'd0, 32'd0, 1'b0);
    check_output("err_wr_mem_we", {31'd0, obs_mem_we}, 32'd0);
    check_output("err_wr_err", {31'd0, rsp_err}, 32'd1);

    // Randomized traffic; each requester holds its request until accepted.
    req_valid = 2'b00;
    last_g = -1;
    for (int i = 0; i < 400; i++) begin
      if (!req_valid[0] || last_g == 0) begin
        req_valid[0] = ($urandom_range(0, 3) != 0);
        req_we[0]    = 1'($urandom_range(0, 1));
        req_addr0    = rand_addr();
        req_wdata0   = $urandom();
      end
      if (!req_valid[1] || last_g == 1) begin
        req_valid[1] = ($urandom_range(0, 3) != 0);
        req_we[1]    = 1'($urandom_range(0, 1));
        req_addr1    = rand_addr();
        req_wdata1   = $urandom();
        req_lock     = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
